// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate divider, h/v counters, sync and active decode.
// Optional VGA_FRAME_CNT_EN adds a 16-bit frame counter output.
module vga_timing_gen #(
  parameter int CLK_DIV = 2,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int H_ACT   = 640,
  parameter int H_FP    = 16,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter int V_ACT   = 480,
  parameter int V_FP    = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       pix_tick,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       valid,
  output logic       hsync,
  output logic       vsync,
`ifdef VGA_FRAME_CNT_EN
  output logic       frame_start,
  output logic [15:0] frame_cnt
`else
  output logic       frame_start
`endif
);

  localparam int H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOT = V_SYNC + V_BP + V_ACT + V_FP;

  localparam logic [3:0]  DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [9:0]  H_LAST   = 10'(H_TOT - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOT - 1);
  // 11-bit bounds so an active segment ending exactly at 1024 still compares correctly
  localparam logic [10:0] H_SYNC_E = 11'(H_SYNC);
  localparam logic [10:0] H_ACT_S  = 11'(H_SYNC + H_BP);
  localparam logic [10:0] H_ACT_E  = 11'(H_SYNC + H_BP + H_ACT);
  localparam logic [10:0] V_SYNC_E = 11'(V_SYNC);
  localparam logic [10:0] V_ACT_S  = 11'(V_SYNC + V_BP);
  localparam logic [10:0] V_ACT_E  = 11'(V_SYNC + V_BP + V_ACT);

  logic [3:0]  div_cnt;
  logic [3:0]  div_nxt;
  logic [9:0]  h_nxt;
  logic [9:0]  v_nxt;
  logic [10:0] h_ext;
  logic [10:0] v_ext;
  logic        h_wrap;
  logic        v_wrap;

  always_comb begin
    div_nxt = (div_cnt == DIV_LAST) ? 4'd0 : div_cnt + 4'd1;
    h_wrap  = pix_tick && (h_cnt == H_LAST);
    v_wrap  = h_wrap && (v_cnt == V_LAST);
    h_nxt   = h_cnt;
    v_nxt   = v_cnt;
    if (pix_tick) h_nxt = h_wrap ? 10'd0 : h_cnt + 10'd1;
    if (h_wrap)   v_nxt = v_wrap ? 10'd0 : v_cnt + 10'd1;
    h_ext   = {1'b0, h_nxt};
    v_ext   = {1'b0, v_nxt};
  end

  // Decodes are taken from the next-state counters so they land on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt     <= 4'd0;
      pix_tick    <= 1'b0;
      h_cnt       <= 10'd0;
      v_cnt       <= 10'd0;
      valid       <= 1'b0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div_cnt     <= div_nxt;
      pix_tick    <= (div_nxt == DIV_LAST);
      h_cnt       <= h_nxt;
      v_cnt       <= v_nxt;
      hsync       <= (h_ext >= H_SYNC_E);
      vsync       <= (v_ext >= V_SYNC_E);
      valid       <= (h_ext >= H_ACT_S) && (h_ext < H_ACT_E) &&
                     (v_ext >= V_ACT_S) && (v_ext < V_ACT_E);
      frame_start <= v_wrap;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      frame_cnt <= 16'd0;
    else if (v_wrap) frame_cnt <= frame_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a default-timing instance for reset/line checks and a short-frame
// instance (default horizontal, 6 lines) for frame, wrap and mid-frame reset checks.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst_s = 1'b0;
  always #5 clk = ~clk;

  logic       pix_tick, valid, hsync, vsync, frame_start;
  logic [9:0] h_cnt, v_cnt;
  logic       s_pix, s_valid, s_hsync, s_vsync, s_fs;
  logic [9:0] s_h, s_v;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt, s_fcnt;
`endif

  vga_timing_gen dut (
    .clk(clk), .rst_n(rst_n), .pix_tick(pix_tick), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .valid(valid), .hsync(hsync), .vsync(vsync),
`ifdef VGA_FRAME_CNT_EN
    .frame_start(frame_start), .frame_cnt(frame_cnt)
`else
    .frame_start(frame_start)
`endif
  );

  vga_timing_gen #(.V_SYNC(2), .V_BP(1), .V_ACT(2), .V_FP(1)) dut_s (
    .clk(clk), .rst_n(rst_s), .pix_tick(s_pix), .h_cnt(s_h), .v_cnt(s_v),
    .valid(s_valid), .hsync(s_hsync), .vsync(s_vsync),
`ifdef VGA_FRAME_CNT_EN
    .frame_start(s_fs), .frame_cnt(s_fcnt)
`else
    .frame_start(s_fs)
`endif
  );

  int checks = 0;
  int failures = 0;
  int n, hs_low, val_cnt, pix_cnt, bad, vs_low, vpix, fs_cnt, run_len, run_state;
  logic [9:0] run_h, run_v, prev_h, prev_v;
  logic       prev_pix, prev_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // run the short-frame DUT until frame_start, remembering the preceding sample
  task automatic wait_fs_s(output int cnt);
    cnt = 0;
    do begin
      prev_h = s_h; prev_v = s_v; prev_pix = s_pix;
      tick();
      cnt++;
    end while (!s_fs && cnt < 12000);
  endtask

  initial begin
    // reset held for 5 clocks
    repeat (5) tick();
    chk("rst_h", h_cnt, 0);
    chk("rst_v", v_cnt, 0);
    chk("rst_pix", pix_tick, 0);
    chk("rst_valid", valid, 0);
    chk("rst_fs", frame_start, 0);
    chk("rst_sync", {hsync, vsync}, 0);
`ifdef VGA_FRAME_CNT_EN
    chk("rst_fcnt", frame_cnt, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("clk1_pix", pix_tick, 1);
    chk("clk1_h", h_cnt, 0);
    tick();
    chk("clk2_pix", pix_tick, 0);
    chk("clk2_h", h_cnt, 1);

    // line 1 of the default raster
    n = 0;
    while (!(h_cnt == 10'd0 && v_cnt == 10'd1) && n < 3000) begin tick(); n++; end
    chk("line1_found", n < 3000, 1);
    hs_low = 0; val_cnt = 0; pix_cnt = 0; bad = 0;
    for (int i = 0; i < 1600; i++) begin
      if (!hsync) hs_low++;
      if (valid) val_cnt++;
      if (pix_tick) pix_cnt++;
      if (hsync !== (h_cnt >= 10'd96)) bad++;
      if (v_cnt !== 10'd1) bad++;
      tick();
    end
    chk("hsync_low", hs_low, 192);
    chk("blank_valid", val_cnt, 0);
    chk("line_pix_ticks", pix_cnt, 800);
    chk("line_consistency", bad, 0);
    chk("line_period_h", h_cnt, 0);
    chk("line_period_v", v_cnt, 2);

    // short-frame DUT: first frame after release has no frame_start
    @(negedge clk);
    rst_s = 1'b1;
    wait_fs_s(n);
    chk("first_fs_delay", n, 9600);
    chk("wrap_prev_h", prev_h, 799);
    chk("wrap_prev_v", prev_v, 5);
    chk("wrap_prev_pix", prev_pix, 1);
    chk("wrap_hv", {s_h, s_v}, 0);
    chk("wrap_sync_valid", {s_hsync, s_vsync, s_valid}, 0);
`ifdef VGA_FRAME_CNT_EN
    chk("fcnt_1", s_fcnt, 1);
`endif

    // one full frame from the pulse
    n = 0; vs_low = 0; vpix = 0; fs_cnt = 0; run_len = 0; run_state = 0;
    run_h = 0; run_v = 0; prev_valid = 0;
    do begin
      if (!s_vsync) vs_low++;
      if (s_pix && s_valid) vpix++;
      if (s_fs) fs_cnt++;
      if (run_state == 0 && s_valid && !prev_valid) begin
        run_state = 1; run_h = s_h; run_v = s_v;
      end
      if (run_state == 1) begin
        if (s_valid) run_len++;
        else run_state = 2;
      end
      prev_valid = s_valid;
      tick();
      n++;
    end while (!s_fs && n < 12000);
    chk("frame_period", n, 9600);
    chk("frame_valid_pixels", vpix, 1280);
    chk("vsync_low", vs_low, 3200);
    chk("fs_pulse_width", fs_cnt, 1);
    chk("valid_run_len", run_len, 1280);
    chk("valid_run_h", run_h, 144);
    chk("valid_run_v", run_v, 3);
    wait_fs_s(n);
    chk("frame_period_3", n, 9600);
`ifdef VGA_FRAME_CNT_EN
    chk("fcnt_3", s_fcnt, 3);
`endif

    // mid-frame reset at (400,3)
    n = 0;
    while (!(s_h == 10'd400 && s_v == 10'd3) && n < 12000) begin tick(); n++; end
    chk("mid_pos_found", n < 12000, 1);
    chk("mid_pre_valid", {s_valid, s_hsync, s_vsync}, 3'b111);
    @(negedge clk);
    rst_s = 1'b0;
    #1;
    chk("async_hv", {s_h, s_v}, 0);
    chk("async_flags", {s_pix, s_valid, s_hsync, s_vsync, s_fs}, 0);
`ifdef VGA_FRAME_CNT_EN
    chk("async_fcnt", s_fcnt, 0);
`endif
    @(negedge clk);
    rst_s = 1'b1;
    wait_fs_s(n);
    chk("restart_fs_delay", n, 9600);

`ifdef VGA_FRAME_CNT_EN
    chk("fcnt_after_rst", s_fcnt, 1);
    @(negedge clk);
    force dut_s.frame_cnt = 16'hFFFF;
    #1;
    release dut_s.frame_cnt;
    wait_fs_s(n);
    chk("fcnt_wrap", s_fcnt, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
